// File: rtl/retospect_lif_neuron.sv
// Leaky integrate-and-fire neuron: signed dendrite weights, a serial configuration chain,
// threshold firing with a refractory period, and leak selected from the clockbox decay bus.
module retospect_lif_neuron #(
    parameter int N_DEND   = 4,
    parameter int W_BITS   = 4,
    parameter int V_BITS   = 8,
    parameter int R_BITS   = 3,
    parameter int CLKBUS_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                config_en,
    input  logic                bs_in,
    output logic                bs_out,
    input  logic                reset_nn,
    input  logic [CLKBUS_W-1:0] clockbus,
    input  logic [N_DEND-1:0]   dendrite,
    output logic                axon,
    output logic [V_BITS-1:0]   potential,
    output logic                refractory
);
    localparam int S_BITS = $clog2(CLKBUS_W);
    localparam int C_BITS = $clog2(N_DEND);
    localparam int SUM_W  = W_BITS + C_BITS + 1;
    localparam int RAW_W  = V_BITS + W_BITS + C_BITS + 2;
    localparam int L      = N_DEND * W_BITS + V_BITS + S_BITS + R_BITS;
    localparam int W_OFF  = V_BITS + S_BITS + R_BITS;

    typedef enum logic {INTEGRATE = 1'b0, REFRAC = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [L-1:0]       chain_q;
    logic [V_BITS-1:0]  pot_q, pot_d;
    logic [R_BITS-1:0]  cnt_q, cnt_d;
    logic               axon_q, axon_d;

    // Chain is one flat vector: w[0] occupies the top bits, refrac_len the bottom, so a
    // right shift moves each field's LSB into the next field's MSB.
    logic signed [W_BITS-1:0] weight [N_DEND];
    logic [V_BITS-1:0]        thresh;
    logic [S_BITS-1:0]        leak_sel;
    logic [R_BITS-1:0]        refrac_len;

    for (genvar gi = 0; gi < N_DEND; gi++) begin : g_weight
        assign weight[gi] = chain_q[W_OFF + (N_DEND-1-gi)*W_BITS +: W_BITS];
    end
    assign thresh     = chain_q[R_BITS+S_BITS +: V_BITS];
    assign leak_sel   = chain_q[R_BITS +: S_BITS];
    assign refrac_len = chain_q[R_BITS-1:0];

    logic signed [SUM_W-1:0] dend_sum;
    logic [V_BITS-1:0]       lv;
    logic signed [RAW_W-1:0] raw;
    logic [V_BITS-1:0]       nv;
    logic                    fire;

    always_comb begin
        dend_sum = '0;
        for (int i = 0; i < N_DEND; i++) begin
            if (dendrite[i]) dend_sum = dend_sum + SUM_W'(weight[i]);
        end
    end

    // Leak is applied before the dendrite sum is added.
    always_comb begin
        lv  = clockbus[leak_sel] ? (pot_q >> 1) : pot_q;
        raw = RAW_W'($signed({1'b0, lv})) + RAW_W'(dend_sum);
        if (raw[RAW_W-1])
            nv = '0;
        else if (|raw[RAW_W-2:V_BITS])
            nv = '1;
        else
            nv = raw[V_BITS-1:0];
        fire = (thresh != '0) && (nv >= thresh);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= INTEGRATE;
        else       state_q <= state_d;
    end

    // Next-state logic: firing is the INTEGRATE->REFRAC edge, skipped for a zero-length period.
    always_comb begin
        state_d = state_q;
        if (reset_nn) begin
            state_d = INTEGRATE;
        end else if (!config_en) begin
            case (state_q)
                INTEGRATE: if (fire && refrac_len != '0) state_d = REFRAC;
                REFRAC:    if (cnt_q <= R_BITS'(1))      state_d = INTEGRATE;
                default:   state_d = INTEGRATE;
            endcase
        end
    end

    // Datapath next values; config_en freezes potential and counter.
    always_comb begin
        pot_d  = pot_q;
        cnt_d  = cnt_q;
        axon_d = 1'b0;
        if (reset_nn) begin
            pot_d = V_BITS'(1);
            cnt_d = '0;
        end else if (!config_en) begin
            case (state_q)
                INTEGRATE: begin
                    if (fire) begin
                        axon_d = 1'b1;
                        pot_d  = '0;
                        cnt_d  = refrac_len;
                    end else begin
                        pot_d  = nv;
                    end
                end
                REFRAC: begin
                    pot_d = '0;
                    cnt_d = cnt_q - R_BITS'(1);
                end
                default: pot_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_q <= '0;
            pot_q   <= '0;
            cnt_q   <= '0;
            axon_q  <= 1'b0;
        end else begin
            pot_q  <= pot_d;
            cnt_q  <= cnt_d;
            axon_q <= axon_d;
            if (!reset_nn && config_en) chain_q <= {bs_in, chain_q[L-1:1]};
        end
    end

    assign axon       = axon_q;
    assign potential  = pot_q;
    assign refractory = (state_q == REFRAC);
    assign bs_out     = chain_q[0];

endmodule

// File: tb/tb_retospect_lif_neuron.sv
// Directed bench for retospect_lif_neuron: config chain, integrate/fire, clamping, leak, async reset.
module tb_retospect_lif_neuron;
    localparam int L = 30;

    logic       clk = 1'b0;
    logic       reset, config_en, bs_in, reset_nn;
    logic [7:0] clockbus;
    logic [3:0] dendrite;
    logic       axon, bs_out, refractory;
    logic [7:0] potential;

    int checks = 0;
    int errors = 0;

    // Expected {axon, refractory, potential} per cycle, and expected bs_out per shift.
    logic [9:0] exp_q[$];
    logic [0:0] bs_q[$];

    logic [L-1:0] cfg_a, cfg_s, cfg_l;

    retospect_lif_neuron dut (
        .clk(clk), .reset(reset), .config_en(config_en), .bs_in(bs_in), .bs_out(bs_out),
        .reset_nn(reset_nn), .clockbus(clockbus), .dendrite(dendrite),
        .axon(axon), .potential(potential), .refractory(refractory)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One run cycle: drive dendrites, queue the expected outcome, clock, compare.
    task automatic step(input string tag, input logic [3:0] d, input logic [7:0] p,
                        input logic a, input logic r);
        logic [9:0] e;
        dendrite = d;
        exp_q.push_back({a, r, p});
        tick();
        e = exp_q.pop_front();
        check(tag, 16'({axon, refractory, potential}), 16'(e));
    endtask

    task automatic nn_reset();
        reset_nn = 1'b1;
        step("reset_nn", 4'b0000, 8'd1, 1'b0, 1'b0);
        reset_nn = 1'b0;
    endtask

    task automatic load(input logic [L-1:0] c);
        for (int i = 0; i < L; i++) begin
            config_en = 1'b1;
            bs_in     = c[i];
            tick();
        end
        config_en = 1'b0;
        bs_in     = 1'b0;
    endtask

    initial begin
        cfg_a = {4'd3, 4'hE, 4'd7, 4'd1, 8'd10, 3'd0, 3'd2};
        cfg_s = {4'd3, 4'hE, 4'd7, 4'd1, 8'd0,  3'd0, 3'd2};
        cfg_l = {4'd3, 4'hE, 4'd7, 4'd1, 8'd10, 3'd1, 3'd2};

        reset = 1'b1; config_en = 1'b0; bs_in = 1'b0; reset_nn = 1'b0;
        clockbus = 8'b0000_0010; dendrite = 4'b0000;
        tick(); tick();
        check("reset_outs", 16'({axon, refractory, potential}), 16'd0);
        check("reset_bs", 16'(bs_out), 16'd0);
        reset = 1'b0;

        // Chain replay: loaded bits come back out of bs_out in shift-in order.
        load(cfg_a);
        for (int j = 0; j < L; j++) begin
            config_en = 1'b1;
            bs_in     = 1'b0;
            bs_q.push_back(cfg_a[j]);
            check($sformatf("replay_%0d", j), 16'(bs_out), 16'(bs_q.pop_front()));
            tick();
        end
        check("cfg_holds_pot", 16'(potential), 16'd0);
        load(cfg_a);

        // Integrate and fire with w0=3, thresh=10, refrac_len=2.
        nn_reset();
        step("int_4",    4'b0001, 8'd4,  1'b0, 1'b0);
        step("int_7",    4'b0001, 8'd7,  1'b0, 1'b0);
        step("fire_10",  4'b0001, 8'd0,  1'b1, 1'b1);
        step("refrac_1", 4'b0001, 8'd0,  1'b0, 1'b1);
        step("refrac_2", 4'b0001, 8'd0,  1'b0, 1'b0);
        step("int_3",    4'b0001, 8'd3,  1'b0, 1'b0);
        step("int_6",    4'b0001, 8'd6,  1'b0, 1'b0);
        step("int_9",    4'b0001, 8'd9,  1'b0, 1'b0);
        step("fire_12",  4'b0001, 8'd0,  1'b1, 1'b1);

        // Config shift in REFRAC freezes the counter; re-shifting cfg_a leaves config intact.
        for (int j = 0; j < L; j++) begin
            config_en = 1'b1;
            bs_in     = cfg_a[j];
            step("cfg_frz", 4'b0001, 8'd0, 1'b0, 1'b1);
        end
        config_en = 1'b0;
        bs_in     = 1'b0;
        step("frz_ref1", 4'b0001, 8'd0, 1'b0, 1'b1);
        step("frz_ref2", 4'b0001, 8'd0, 1'b0, 1'b0);
        step("frz_int3", 4'b0001, 8'd3, 1'b0, 1'b0);

        // Simultaneous dendrites and negative clamp.
        nn_reset();
        step("sim_2",    4'b0011, 8'd2, 1'b0, 1'b0);
        step("sim_3",    4'b0011, 8'd3, 1'b0, 1'b0);
        step("sim_4",    4'b0011, 8'd4, 1'b0, 1'b0);
        nn_reset();
        step("neg_0a",   4'b0010, 8'd0, 1'b0, 1'b0);
        step("neg_0b",   4'b0010, 8'd0, 1'b0, 1'b0);
        step("all_9",    4'b1111, 8'd9, 1'b0, 1'b0);
        step("all_fire", 4'b1111, 8'd0, 1'b1, 1'b1);
        step("all_ref",  4'b0000, 8'd0, 1'b0, 1'b1);
        step("all_int",  4'b0000, 8'd0, 1'b0, 1'b0);

        // Saturation with thresh=0: never fires.
        load(cfg_s);
        nn_reset();
        for (int k = 1; k <= 36; k++) step($sformatf("sat_%0d", k), 4'b0100, 8'(1 + 7*k), 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step("sat_255", 4'b0100, 8'd255, 1'b0, 1'b0);

        // Leak via clockbus[1] (constant high), applied before the sum.
        load(cfg_l);
        nn_reset();
        step("lk_8",   4'b1100, 8'd8, 1'b0, 1'b0);
        step("lk_9",   4'b0110, 8'd9, 1'b0, 1'b0);
        step("lk_4",   4'b0000, 8'd4, 1'b0, 1'b0);
        step("lk_2",   4'b0000, 8'd2, 1'b0, 1'b0);
        step("lk_1",   4'b0000, 8'd1, 1'b0, 1'b0);
        step("lk_0",   4'b0000, 8'd0, 1'b0, 1'b0);
        step("lk_8b",  4'b1100, 8'd8, 1'b0, 1'b0);
        step("lk_7",   4'b0001, 8'd7, 1'b0, 1'b0);
        step("lk_fire", 4'b1101, 8'd0, 1'b1, 1'b1);

        // Async reset in REFRAC clears outputs without a clock edge.
        #2 reset = 1'b1;
        #1 check("arst_refrac", 16'({axon, refractory, potential}), 16'd0);
        tick();
        reset = 1'b0;

        // Async reset mid-shift while potential is nonzero; chain reads back as zeros.
        nn_reset();
        for (int i = 0; i < 15; i++) begin
            config_en = 1'b1;
            bs_in     = cfg_a[i];
            tick();
        end
        check("shift_holds_pot", 16'(potential), 16'd1);
        #2 reset = 1'b1;
        #1 check("arst_shift", 16'({axon, refractory, potential}), 16'd0);
        tick();
        reset = 1'b0;
        for (int j = 0; j < L; j++) begin
            config_en = 1'b1;
            bs_in     = 1'b0;
            bs_q.push_back(1'b0);
            check($sformatf("zero_rd_%0d", j), 16'(bs_out), 16'(bs_q.pop_front()));
            tick();
        end
        config_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/retospect_lif_neuron.md
Name: retospect_lif_neuron

Overview:
Parametrised leaky integrate-and-fire neuron cell. It is the next generation of the fabric's configurable neuron block. It generalises dendrite count, weight width and potential width. It adds signed weights, a configurable firing threshold, a refractory period, and accumulation of all active dendrites in the same cycle. It sits in the neuron array on the shared configuration bitstream chain and consumes the clockbox decay bus.

Parameters:
N_DEND, 4, number of dendrite inputs (1..8)
W_BITS, 4, width of each signed two's-complement weight (2..8)
V_BITS, 8, width of the unsigned membrane potential and threshold (4..16)
R_BITS, 3, width of the refractory-length field
CLKBUS_W, 8, width of the decay clock bus (power of 2); selector width S_BITS = clog2(CLKBUS_W)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high; clears all state and config
config_en  in  1  bitstream shift enable
bs_in  in  1  serial config in
bs_out  out  1  serial config out (LSB of last config field)
reset_nn  in  1  synchronous network reset; config is kept
clockbus  in  CLKBUS_W  decay strobes from the clockbox
dendrite  in  N_DEND  spike inputs
axon  out  1  registered one-cycle spike output
potential  out  V_BITS  current membrane potential (observation)
refractory  out  1  high while in REFRAC state

Behaviour:
- Config chain: total length L = N_DEND*W_BITS + V_BITS + S_BITS + R_BITS.
- Chain field order: w[0], w[1] .. w[N_DEND-1], thresh, leak_sel, refrac_len.
- Each field shifts right. The incoming bit enters the field MSB; the field LSB feeds the next field's MSB. bs_out = refrac_len[0].
- Priority per clock edge: reset (async) > reset_nn > config_en > run.
- reset (async): all weights, thresh, leak_sel, refrac_len, potential and refractory counter go to 0; state = INTEGRATE; axon = 0; bs_out = 0.
- reset_nn: potential <= 1; state <= INTEGRATE; counter <= 0; axon <= 0; config unchanged.
- config_en: chain shifts one bit per cycle; potential, state and counter are held; axon <= 0.
- FSM states: INTEGRATE, REFRAC. Firing is not a state; it is the INTEGRATE->REFRAC transition.
- INTEGRATE arithmetic:
  - Leaked value lv = potential>>1 if clockbus[leak_sel], else potential.
  - sum = signed sum of w[i] over all i with dendrite[i]=1, computed at width W_BITS+clog2(N_DEND)+1.
  - raw = lv + sum at width V_BITS+W_BITS+clog2(N_DEND)+2, signed.
  - Clamp raw to [0, 2^V_BITS-1] to give nv.
- Fire condition: thresh != 0 and nv >= thresh.
- On fire: axon <= 1 for exactly one cycle; potential <= 0; counter <= refrac_len.
  - State <= REFRAC if refrac_len != 0, else state stays INTEGRATE.
- No fire: potential <= nv; axon <= 0.
- thresh == 0: the neuron never fires; potential still integrates and saturates.
- REFRAC: dendrites and leak are ignored; potential held at 0; counter decrements each cycle.
  - When counter reaches 1, the next edge returns the FSM to INTEGRATE.
  - Refractory duration is exactly refrac_len cycles.
- Simultaneous dendrites: all contributions are summed; no last-wins behaviour.
- Leak and spikes in the same cycle: leak is applied first, then the sum.
- Saturation boundaries: raw > 2^V_BITS-1 gives all-ones; raw < 0 gives 0.
- config_en asserted mid-REFRAC: the counter freezes and resumes when config_en drops.
- reset asserted mid-shift: the partial config is lost (all zeros).
- leak_sel indexes clockbus directly: bit 0 = never leak, bit 1 = always leak, per the clockbox convention.

Test Plan:
Config load: with N=4, W=4, V=8, R=3, S=3 (L=30), shift 30 bits with w0=3, w1=-2, w2=7, w3=1, thresh=10, leak_sel=0, refrac_len=2, then 30 zeros -> bs_out replays the loaded pattern starting at cycle 31.
Integrate/fire: reset_nn, then dendrite=0001 held -> potential 4, 7, 10; at the edge where nv=10, axon=1 for one cycle, potential=0, refractory=1 for 2 cycles; then potential 3, 6, 9, 12 -> fires again.
Simultaneous and negative: potential=1, dendrite=0011 -> +1 per cycle; dendrite=0010 alone from potential 1 -> clamps to 0 and stays at 0.
Saturation: thresh=0, w2=7, dendrite=0100 held -> potential climbs 1, 8 ... 246, 253, 255 and holds at 255; axon never asserts.
Leak: leak_sel=1, potential=9, no spikes -> 4, 2, 1, 0; with dendrite0 active from 8 -> 4+3=7.
Reset mid-op: assert reset asynchronously during REFRAC and during a config shift -> axon, refractory and potential go to 0 immediately without a clock edge; a re-read of the chain returns all zeros.
